// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode constants, control-field encodings,
// the decoded-control struct and the skid-buffer state type.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_SRET   = 32'h1020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    // Functional unit selected by fn
    localparam logic [2:0] FN_ALU    = 3'd0;
    localparam logic [2:0] FN_BRANCH = 3'd1;
    localparam logic [2:0] FN_MULDIV = 3'd2;
    localparam logic [2:0] FN_MEM    = 3'd3;
    localparam logic [2:0] FN_CSR    = 3'd4;

    localparam logic [1:0] BSEL_RS2 = 2'd0;
    localparam logic [1:0] BSEL_IMM = 2'd1;
    localparam logic [1:0] BSEL_PC4 = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] MEM_NONE = 4'b0000;

    typedef struct packed {
        logic [3:0] alu_fn;
        logic [2:0] fn;
        logic [1:0] b_sel;
        logic       we;
        logic       csr_we;
        logic [3:0] mem_op;
        logic [2:0] muldiv_op;
        logic       branch;
        logic       bneq;
        logic       j;
        logic       jr;
        logic       lui;
        logic       auipc;
        logic       word;
        logic       ecall;
        logic       ebreak;
        logic       mret;
        logic       sret;
        logic       wfi;
    } decode_ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    // Loads carry funct3 directly (1_fff); stores carry the access size (01_ss).
    function automatic logic [3:0] load_op(input logic [2:0] funct3);
        return {1'b1, funct3};
    endfunction

    function automatic logic [3:0] store_op(input logic [1:0] size);
        return {2'b01, size};
    endfunction

endpackage

// File: rtl/rv_decode.sv
// Pure combinational RISC-V instruction decoder producing decode_ctrl_t and an illegal flag.
// An illegal instruction yields an all-zero control word.
module rv_decode
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int M_EXT   = 1,
    parameter int CSR_EXT = 1
) (
    input  logic [31:0]  i_instr,
    output decode_ctrl_t o_ctrl,
    output logic         o_illegal
);

    localparam bit IS64    = (XLEN == 64);
    localparam bit HAS_M   = (M_EXT != 0);
    localparam bit HAS_CSR = (CSR_EXT != 0);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic         w_f7_zero;
    logic         w_f7_alt;
    logic         w_f7_muldiv;
    logic         w_shl_imm_ok;
    logic         w_shr_imm_ok;
    logic [3:0]   w_imm_alu_fn;
    decode_ctrl_t w_ctrl;
    logic         w_legal;

    assign w_opcode    = i_instr[6:0];
    assign w_funct3    = i_instr[14:12];
    assign w_funct7    = i_instr[31:25];
    assign w_f7_zero   = (w_funct7 == 7'b0000000);
    assign w_f7_alt    = (w_funct7 == 7'b0100000);
    assign w_f7_muldiv = (w_funct7 == 7'b0000001);

    // RV64 shifts take a 6-bit shamt, so only bits [31:26] form the function field.
    assign w_shl_imm_ok = IS64 ? (i_instr[31:26] == 6'b000000)
                               : w_f7_zero;
    assign w_shr_imm_ok = IS64 ? (i_instr[31:26] == 6'b000000 || i_instr[31:26] == 6'b010000)
                               : (w_f7_zero || w_f7_alt);
    assign w_imm_alu_fn = {(w_funct3 == 3'b101) & i_instr[30], w_funct3};

    always_comb begin
        w_ctrl  = '0;
        w_legal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_ctrl.we = 1'b1;
                if (w_f7_zero || (w_f7_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
                    w_legal       = 1'b1;
                    w_ctrl.alu_fn = {i_instr[30], w_funct3};
                end else if (w_f7_muldiv && HAS_M) begin
                    w_legal          = 1'b1;
                    w_ctrl.fn        = FN_MULDIV;
                    w_ctrl.muldiv_op = w_funct3;
                end
            end
            OPC_OP_32: begin
                w_ctrl.we   = 1'b1;
                w_ctrl.word = 1'b1;
                if (IS64) begin
                    if ((w_f7_zero && (w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b101)) ||
                        (w_f7_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
                        w_legal       = 1'b1;
                        w_ctrl.alu_fn = {i_instr[30], w_funct3};
                    end else if (w_f7_muldiv && HAS_M && (w_funct3 == 3'b000 || w_funct3[2])) begin
                        w_legal          = 1'b1;
                        w_ctrl.fn        = FN_MULDIV;
                        w_ctrl.muldiv_op = w_funct3;
                    end
                end
            end
            OPC_OP_IMM: begin
                w_ctrl.we     = 1'b1;
                w_ctrl.b_sel  = BSEL_IMM;
                w_ctrl.alu_fn = w_imm_alu_fn;
                case (w_funct3)
                    3'b001:  w_legal = w_shl_imm_ok;
                    3'b101:  w_legal = w_shr_imm_ok;
                    default: w_legal = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                w_ctrl.we     = 1'b1;
                w_ctrl.word   = 1'b1;
                w_ctrl.b_sel  = BSEL_IMM;
                w_ctrl.alu_fn = w_imm_alu_fn;
                if (IS64) begin
                    case (w_funct3)
                        3'b000:  w_legal = 1'b1;
                        3'b001:  w_legal = w_f7_zero;
                        3'b101:  w_legal = w_f7_zero || w_f7_alt;
                        default: w_legal = 1'b0;
                    endcase
                end
            end
            OPC_LOAD: begin
                w_ctrl.we     = 1'b1;
                w_ctrl.fn     = FN_MEM;
                w_ctrl.b_sel  = BSEL_IMM;
                w_ctrl.mem_op = load_op(w_funct3);
                case (w_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = IS64;
                    default:                                w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_ctrl.fn     = FN_MEM;
                w_ctrl.b_sel  = BSEL_IMM;
                w_ctrl.mem_op = store_op(w_funct3[1:0]);
                w_legal       = !w_funct3[2] && (w_funct3[1:0] != 2'b11 || IS64);
            end
            OPC_BRANCH: begin
                w_ctrl.fn     = FN_BRANCH;
                w_ctrl.branch = 1'b1;
                w_ctrl.bneq   = w_funct3[0];
                w_ctrl.alu_fn = {1'b1, w_funct3};
                w_legal       = (w_funct3[2:1] != 2'b01);
            end
            OPC_JAL: begin
                w_ctrl.fn    = FN_BRANCH;
                w_ctrl.j     = 1'b1;
                w_ctrl.we    = 1'b1;
                w_ctrl.b_sel = BSEL_PC4;
                w_legal      = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.fn    = FN_BRANCH;
                w_ctrl.jr    = 1'b1;
                w_ctrl.we    = 1'b1;
                w_ctrl.b_sel = BSEL_PC4;
                w_legal      = (w_funct3 == 3'b000);
            end
            OPC_LUI: begin
                w_ctrl.lui   = 1'b1;
                w_ctrl.we    = 1'b1;
                w_ctrl.b_sel = BSEL_IMM;
                w_legal      = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.auipc = 1'b1;
                w_ctrl.we    = 1'b1;
                w_ctrl.b_sel = BSEL_IMM;
                w_legal      = 1'b1;
            end
            OPC_SYSTEM: begin
                w_ctrl.fn = FN_CSR;
                if (HAS_CSR) begin
                    if (w_funct3 == 3'b000) begin
                        w_legal = 1'b1;
                        case (i_instr)
                            INSTR_ECALL:  w_ctrl.ecall  = 1'b1;
                            INSTR_EBREAK: w_ctrl.ebreak = 1'b1;
                            INSTR_MRET:   w_ctrl.mret   = 1'b1;
                            INSTR_SRET:   w_ctrl.sret   = 1'b1;
                            INSTR_WFI:    w_ctrl.wfi    = 1'b1;
                            default:      w_legal       = 1'b0;
                        endcase
                    end else if (w_funct3 != 3'b100) begin
                        w_legal       = 1'b1;
                        w_ctrl.we     = 1'b1;
                        w_ctrl.csr_we = 1'b1;
                        w_ctrl.alu_fn = {1'b0, w_funct3};
                        w_ctrl.b_sel  = w_funct3[2] ? BSEL_IMM : BSEL_RS2;
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign o_ctrl    = w_legal ? w_ctrl : '0;
    assign o_illegal = ~w_legal;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes at the input and holds results in a 2-entry in-order
// skid buffer so in_ready is a plain register with no path from out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int M_EXT   = 1,
    parameter int CSR_EXT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            exception_pending,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output decode_ctrl_t    out_ctrl,
    output logic            out_illegal,
    output buf_state_t      o_dbg_state
);

    buf_state_t      r_state;
    buf_state_t      w_next_state;
    logic            r_in_ready;

    logic [XLEN-1:0] r_head_pc;
    logic [31:0]     r_head_instr;
    decode_ctrl_t    r_head_ctrl;
    logic            r_head_illegal;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_skid_instr;
    decode_ctrl_t    r_skid_ctrl;
    logic            r_skid_illegal;

    decode_ctrl_t    w_dec_ctrl;
    logic            w_dec_illegal;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_ld_head_in;
    logic            w_ld_head_skid;
    logic            w_ld_skid;

    rv_decode #(
        .XLEN    (XLEN),
        .M_EXT   (M_EXT),
        .CSR_EXT (CSR_EXT)
    ) u_rv_decode (
        .i_instr   (in_instr),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    assign w_in_fire  = in_valid & r_in_ready & ~flush;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_TWO);
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_ld_head_in   = 1'b0;
        w_ld_head_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_next_state = ST_ONE;
                    w_ld_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_ld_head_in = 1'b1;
                end else if (w_in_fire) begin
                    w_next_state = ST_TWO;
                    w_ld_skid    = 1'b1;
                end else if (w_out_fire) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only an issue can happen
                if (w_out_fire) begin
                    w_next_state   = ST_ONE;
                    w_ld_head_skid = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
        if (flush) begin
            w_next_state   = ST_EMPTY;
            w_ld_head_in   = 1'b0;
            w_ld_head_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_pc      <= '0;
            r_head_instr   <= INSTR_NOP;
            r_head_ctrl    <= '0;
            r_head_illegal <= 1'b0;
            r_skid_pc      <= '0;
            r_skid_instr   <= INSTR_NOP;
            r_skid_ctrl    <= '0;
            r_skid_illegal <= 1'b0;
        end else begin
            if (w_ld_head_in) begin
                r_head_pc      <= in_pc;
                r_head_instr   <= in_instr;
                r_head_ctrl    <= w_dec_ctrl;
                r_head_illegal <= w_dec_illegal;
            end else if (w_ld_head_skid) begin
                r_head_pc      <= r_skid_pc;
                r_head_instr   <= r_skid_instr;
                r_head_ctrl    <= r_skid_ctrl;
                r_head_illegal <= r_skid_illegal;
            end
            if (w_ld_skid) begin
                r_skid_pc      <= in_pc;
                r_skid_instr   <= in_instr;
                r_skid_ctrl    <= w_dec_ctrl;
                r_skid_illegal <= w_dec_illegal;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_pc      = r_head_pc;
    assign out_instr   = r_head_instr;
    assign out_illegal = r_head_illegal;
    assign o_dbg_state = r_state;

    // Exception suppression is applied at issue time so a late exception still blocks the write.
    always_comb begin
        out_ctrl    = r_head_ctrl;
        out_ctrl.we = r_head_ctrl.we & ~exception_pending;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width; legal values 32 or 64.
REQ-002 SHALL have parameter M_EXT, default 1, enable for RV M-extension decode.
REQ-003 SHALL have parameter CSR_EXT, default 1, enable for SYSTEM/Zicsr decode.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1: upstream fetch handshake.
REQ-007 SHALL have ports in_instr in 32 and in_pc in XLEN: fetched word and its PC.
REQ-008 SHALL have port flush  in  1  discard all held and incoming instructions.
REQ-009 SHALL have port exception_pending  in  1  from commit; suppresses register write-enable.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1: downstream execute handshake.
REQ-011 SHALL have ports out_pc out XLEN, out_instr out 32, out_ctrl out decode_ctrl_t, out_illegal out 1.

Function
REQ-012 SHALL register decode results: an instruction accepted at edge N appears on outputs after edge N when the buffer is empty; latency 1 cycle.
REQ-013 SHALL hold a 2-entry in-order skid buffer with states EMPTY, ONE, TWO; transfer occurs when valid&ready on that side.
REQ-014 SHALL drive in_ready = (state != TWO), registered, no combinational path from out_ready.
REQ-015 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-016 Simultaneous accept and issue SHALL leave the occupancy unchanged; in TWO, issue frees one slot for the next cycle.
REQ-017 flush=1 SHALL force state EMPTY and out_valid=0 at the next edge; in_valid is ignored in the flush cycle; flush wins over every other event.
REQ-018 SHALL decode RV32I opcodes LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC, and SYSTEM when CSR_EXT=1.
REQ-019 When XLEN=64 SHALL also decode OP-IMM-32 (0011011) and OP-32 (0111011) and set ctrl.word, plus LD/LWU/SD with 6-bit shamt checks.
REQ-020 out_ctrl fields: alu_fn[3:0] ({bit30,funct3}; sub/branch-compare = 1xxx), fn[2:0], b_sel[1:0], we, csr_we, mem_op[3:0], muldiv_op[2:0], branch, bneq, j, jr, lui, auipc, word, ecall, ebreak, mret, sret, wfi.
REQ-021 out_illegal SHALL be set for: undefined opcode; op[1:0] != 11; reserved funct3/funct7 combinations; M-op with M_EXT=0; SYSTEM with CSR_EXT=0; word ops or shamt[5]=1 with XLEN=32.
REQ-022 An illegal instruction SHALL have every enable in out_ctrl (we, csr_we, mem_op, branch, j, jr) forced to zero.
REQ-023 out_ctrl.we SHALL equal decoded write-enable AND NOT exception_pending, sampled at the issue cycle (combinational from the held entry).
REQ-024 Writes to x0 SHALL still be decoded with we=1; suppression is the regfile's responsibility.

Reset
REQ-025 On rst: state EMPTY, out_valid=0, in_ready=1, out_pc=0, out_instr=0x00000013 (NOP), out_ctrl all zero, out_illegal=0.
REQ-026 Reset asserted mid-transfer SHALL drop all buffered entries; nothing is issued on release until a new in_valid.

Structure
REQ-027 decode_ctrl_t, opcode constants, alu_fn/fn/mem_op/muldiv_op encodings SHALL live in package decode_pkg.
REQ-028 Pure combinational decode SHALL be a sub-module rv_decode (instr, parameters -> decode_ctrl_t, illegal), instantiated once at the buffer input.

Verification
REQ-029 0x003100B3 (add x1,x2,x3), out_ready=1 -> out_valid next cycle, alu_fn=0000, fn=000, we=1, illegal=0.
REQ-030 0x02208033 (mul) with M_EXT=0 -> out_illegal=1, we=0; with M_EXT=1 -> fn=010, muldiv_op=000, illegal=0.
REQ-031 0x0010809B (addiw) with XLEN=64 -> word=1, b_sel=01, illegal=0; with XLEN=32 -> illegal=1.
REQ-032 out_ready=0 for 3 cycles with 3 back-to-back instructions -> in_ready=0 after 2 accepted; on release, PCs issued in order with no loss or duplication.
REQ-033 flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle instruction never issued.
REQ-034 exception_pending=1 while an add is held -> out_ctrl.we=0; deasserting it before issue -> we=1.
